adc78h90_poller: RTL and testbench



---
 rtl/adc78h90_poller.sv | 165 ++++++++++++++++
 tb/tb_adc78h90_poller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc78h90_poller.sv
// Free-running SPI scanner for the ADC78H90: polls every channel in CH_MASK and strobes each result.
// Define ADC78H90_AVG_EN to emit one 4-sample per-channel average instead of every raw result.
module adc78h90_poller #(
  parameter int         DIV     = 4,
  parameter logic [7:0] CH_MASK = 8'b0000_1110,
  parameter int         GAP     = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        nADCCS,
  output logic        ADCCLK,
  output logic        ADCMOSI,
  input  logic        ADCMISO,
  output logic        out_valid,
  output logic [2:0]  out_ch,
  output logic [11:0] out_data
);
  localparam logic ST_GAP   = 1'b0;
  localparam logic ST_FRAME = 1'b1;

  function automatic logic [2:0] lowest_addr(input logic [7:0] mask);
    logic [2:0] res;
    res = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (mask[k]) res = 3'(k);
    end
    return res;
  endfunction

  // Nearest enabled channel above a, wrapping; a itself when it is the only one.
  function automatic logic [2:0] next_addr(input logic [2:0] a);
    logic [2:0] res;
    res = a;
    for (int k = 7; k >= 1; k--) begin
      if (CH_MASK[3'(a + 3'(k))]) res = 3'(a + 3'(k));
    end
    return res;
  endfunction

  localparam logic [2:0] FIRST_ADDR = lowest_addr(CH_MASK);

  logic        r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_bit;
  logic        r_half;
  logic [15:0] r_ctrl;
  logic [11:0] r_shreg;  // only the last 12 bits of each frame carry data
  logic [2:0]  r_addr;
  logic [2:0]  r_prev_addr;
  logic        r_first;
  logic        r_ncs;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_valid;
  logic [2:0]  r_ch;
  logic [11:0] r_data;
  logic [11:0] w_result;

  assign w_result = r_shreg;

`ifdef ADC78H90_AVG_EN
  logic [13:0] r_acc  [8];
  logic [1:0]  r_navg [8];
  logic [13:0] w_sum;
  assign w_sum = r_acc[r_prev_addr] + 14'(w_result);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_GAP;
      r_cnt       <= 16'd0;
      r_bit       <= 4'd0;
      r_half      <= 1'b0;
      r_ctrl      <= 16'd0;
      r_shreg     <= 12'd0;
      r_addr      <= FIRST_ADDR;
      r_prev_addr <= FIRST_ADDR;
      r_first     <= 1'b1;
      r_ncs       <= 1'b1;
      r_sclk      <= 1'b1;
      r_mosi      <= 1'b0;
      r_valid     <= 1'b0;
      r_ch        <= 3'd0;
      r_data      <= 12'd0;
`ifdef ADC78H90_AVG_EN
      for (int n = 0; n < 8; n++) begin
        r_acc[n]  <= 14'd0;
        r_navg[n] <= 2'd0;
      end
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_GAP: begin
          if (r_cnt == 16'(GAP - 1)) begin
            r_state <= ST_FRAME;
            r_cnt   <= 16'd0;
            r_bit   <= 4'd0;
            r_half  <= 1'b0;
            r_ncs   <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            // Control word {00, addr, 0...} pre-shifted: its MSB is already on ADCMOSI.
            r_ctrl  <= {1'b0, r_addr, 12'd0};
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          if (r_cnt != 16'(DIV - 1)) begin
            r_cnt <= r_cnt + 16'd1;
          end else begin
            r_cnt <= 16'd0;
            if (!r_half) begin
              r_half  <= 1'b1;
              r_sclk  <= 1'b1;
              r_shreg <= {r_shreg[10:0], ADCMISO};
            end else if (r_bit != 4'd15) begin
              r_half <= 1'b0;
              r_sclk <= 1'b0;
              r_bit  <= r_bit + 4'd1;
              r_mosi <= r_ctrl[15];
              r_ctrl <= {r_ctrl[14:0], 1'b0};
            end else begin
              r_state     <= ST_GAP;
              r_ncs       <= 1'b1;
              r_half      <= 1'b0;
              r_prev_addr <= r_addr;
              r_addr      <= next_addr(r_addr);
              // The ADC returns the channel addressed one frame earlier.
              if (r_first) begin
                r_first <= 1'b0;
              end else begin
`ifdef ADC78H90_AVG_EN
                if (r_navg[r_prev_addr] == 2'd3) begin
                  r_valid              <= 1'b1;
                  r_ch                 <= r_prev_addr;
                  r_data               <= w_sum[13:2];
                  r_acc[r_prev_addr]   <= 14'd0;
                  r_navg[r_prev_addr]  <= 2'd0;
                end else begin
                  r_acc[r_prev_addr]   <= w_sum;
                  r_navg[r_prev_addr]  <= r_navg[r_prev_addr] + 2'd1;
                end
`else
                r_valid <= 1'b1;
                r_ch    <= r_prev_addr;
                r_data  <= w_result;
`endif
              end
            end
          end
        end
      endcase
    end
  end

  assign nADCCS    = r_ncs;
  assign ADCCLK    = r_sclk;
  assign ADCMOSI   = r_mosi;
  assign out_valid = r_valid;
  assign out_ch    = r_ch;
  assign out_data  = r_data;

endmodule

// File: tb/tb_adc78h90_poller.sv
// Bench for adc78h90_poller: two instances (three-channel scan and single channel) driven by
// behavioural ADC models with random conversions; results checked through per-instance scoreboards.
`timescale 1ns/1ps
module tb_adc78h90_poller;
  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_main = 1'b1;
  logic end_req  = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int         DIVV   = (gi == 0) ? 4 : 3;
    localparam int         GAPV   = (gi == 0) ? 8 : 5;
    localparam logic [7:0] MASK   = (gi == 0) ? 8'h0E : 8'h80;
    localparam int         PERIOD = 32 * DIVV + GAPV;

    logic        rst_local = 1'b0;
    logic        rst_dut;
    logic        ncs, sclk, mosi, valid;
    logic        miso = 1'b0;
    logic [2:0]  ch;
    logic [11:0] data;
    logic        done = 1'b0;

    assign rst_dut = rst_main | rst_local;

    adc78h90_poller #(.DIV(DIVV), .CH_MASK(MASK), .GAP(GAPV)) dut (
      .clk      (clk),
      .rst      (rst_dut),
      .nADCCS   (ncs),
      .ADCCLK   (sclk),
      .ADCMOSI  (mosi),
      .ADCMISO  (miso),
      .out_valid(valid),
      .out_ch   (ch),
      .out_data (data)
    );

    // n-th channel of the scan (0-based), i.e. enabled channels in ascending order, repeating.
    function automatic int nth_ch(input int n);
      int k;
      int r;
      k = n % $countones(MASK);
      r = -1;
      for (int c = 0; c < 8; c++) begin
        if (MASK[c] && r < 0) begin
          if (k == 0) r = c;
          else k--;
        end
      end
      return r;
    endfunction

    logic [14:0] exp_q[$];
    int          frames = 0, rises = 0, half_len = 0, mosi_age = 0, pushes = 0;
    logic        prev_ncs = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0, in_frame = 1'b0;
    logic [15:0] din = 16'd0, word = 16'd0;
    int          acc [8];
    int          navg [8];

    // ADC model and expectation source: decodes DIN, shifts out a random word per frame.
    always @(negedge clk) begin
      int c;
      if (rst_dut) begin
        frames   = 0;
        in_frame = 1'b0;
        rises    = 0;
        miso     = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
          acc[k]  = 0;
          navg[k] = 0;
        end
      end else if (prev_ncs && !ncs) begin
        in_frame = 1'b1;
        rises    = 0;
        half_len = 1;
        din      = 16'd0;
        word     = (gi == 1 && $urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        miso     = word[15];
      end else if (in_frame && !ncs) begin
        if (sclk != prev_sclk) begin
          vectors++;
          if (half_len != DIVV) begin
            miscompares++;
            $display("FAIL half_len[%0d] frame %0d edge %0d: got %0d cycles, want %0d", gi, frames, rises, half_len, DIVV);
          end
          half_len = 1;
          if (sclk) begin
            vectors++;
            if (mosi_age < DIVV) begin
              miscompares++;
              $display("FAIL din_setup[%0d] frame %0d edge %0d: stable %0d cycles, want >= %0d", gi, frames, rises, mosi_age, DIVV);
            end
            din = {din[14:0], mosi};
            rises++;
            if (rises == 5) begin
              vectors++;
              if (int'(din[2:0]) != nth_ch(frames)) begin
                miscompares++;
                $display("FAIL din_addr[%0d] frame %0d: got %0d, want %0d", gi, frames, din[2:0], nth_ch(frames));
              end
            end
            if (rises == 16 && frames >= 1) begin
              c = nth_ch(frames - 1);
`ifdef ADC78H90_AVG_EN
              acc[c]  += int'(word[11:0]);
              navg[c] += 1;
              if (navg[c] == 4) begin
                exp_q.push_back({3'(c), 12'(acc[c] / 4)});
                pushes++;
                acc[c]  = 0;
                navg[c] = 0;
              end
`else
              exp_q.push_back({3'(c), word[11:0]});
              pushes++;
`endif
            end
          end else begin
            miso = word[15 - rises];
          end
        end else begin
          half_len++;
          if (sclk) begin
            vectors++;
            if (mosi != prev_mosi) begin
              miscompares++;
              $display("FAIL din_hold[%0d] frame %0d edge %0d: ADCMOSI changed while SCLK high", gi, frames, rises);
            end
          end
        end
      end else if (in_frame && ncs) begin
        vectors++;
        if (rises != 16 || half_len != DIVV) begin
          miscompares++;
          $display("FAIL frame_shape[%0d] frame %0d: got %0d edges / last half %0d, want 16 / %0d", gi, frames, rises, half_len, DIVV);
        end
        in_frame = 1'b0;
        frames++;
      end
      mosi_age  = (mosi != prev_mosi) ? 1 : mosi_age + 1;
      prev_ncs  = ncs;
      prev_sclk = sclk;
      prev_mosi = mosi;
    end

    // Monitor: every strobe must match the oldest outstanding expectation.
    longint mcyc = 0, last_strobe = 0;
    always @(negedge clk) begin
      logic [14:0] e;
      mcyc++;
      if (valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL strobe[%0d]: unexpected ch=%0d data=%03h, want no strobe", gi, ch, data);
        end else begin
          e = exp_q.pop_front();
          if ({ch, data} !== e) begin
            miscompares++;
            $display("FAIL strobe[%0d]: got ch=%0d data=%03h, want ch=%0d data=%03h", gi, ch, data, e[14:12], e[11:0]);
          end
        end
`ifndef ADC78H90_AVG_EN
        if (last_strobe != 0) begin
          vectors++;
          if (mcyc - last_strobe != longint'(PERIOD)) begin
            miscompares++;
            $display("FAIL spacing[%0d]: got %0d cycles, want %0d", gi, mcyc - last_strobe, PERIOD);
          end
        end
`endif
        last_strobe = mcyc;
      end
      if (rst_dut) last_strobe = 0;
    end

    initial begin : reset_chk
      int n;
      @(posedge clk); #1;
      vectors++;
      if (ncs !== 1'b1 || sclk !== 1'b1 || mosi !== 1'b0 || valid !== 1'b0 || ch !== 3'd0 || data !== 12'd0) begin
        miscompares++;
        $display("FAIL reset_vals[%0d]: got cs=%b clk=%b din=%b v=%b ch=%0d d=%03h, want 1 1 0 0 0 000", gi, ncs, sclk, mosi, valid, ch, data);
      end
      wait (rst_main == 1'b0);
      n = 0;
      while (n < 1000) begin
        @(posedge clk); #1;
        n++;
        if (!ncs) break;
      end
      vectors++;
      if (n != GAPV) begin
        miscompares++;
        $display("FAIL first_gap[%0d]: CS high %0d cycles after release, want %0d", gi, n, GAPV);
      end
    end

    if (gi == 0) begin : g_mid
      initial begin : mid_rst
        int n;
        n = 0;
        wait (rst_main == 1'b0);
        while (n < 20000) begin
          @(posedge clk); #1;
          n++;
          if (in_frame && frames == 2 && rises == 9) break;
        end
        vectors++;
        if (n >= 20000) begin
          miscompares++;
          $display("FAIL mid_trigger[%0d]: edge 9 of frame 3 not reached in %0d cycles", gi, n);
        end
        rst_local = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (ncs !== 1'b1 || sclk !== 1'b1 || valid !== 1'b0) begin
          miscompares++;
          $display("FAIL mid_reset[%0d]: got cs=%b clk=%b v=%b, want 1 1 0", gi, ncs, sclk, valid);
        end
        rst_local = 1'b0;
      end
    end

    initial begin : end_chk
      int n;
      int hi;
      wait (end_req == 1'b1);
      n  = 0;
      hi = 0;
      while (hi < 3 && n < 1000) begin
        @(negedge clk);
        n++;
        hi = ncs ? hi + 1 : 0;
      end
      vectors++;
      if (hi < 3) begin
        miscompares++;
        $display("FAIL end_idle[%0d]: CS never idle, got %0d high cycles, want 3", gi, hi);
      end
      vectors++;
      if (exp_q.size() != 0 || pushes == 0) begin
        miscompares++;
        $display("FAIL drain[%0d]: got %0d pending of %0d expected strobes, want 0 pending of >0", gi, exp_q.size(), pushes);
      end
      done = 1'b1;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_main = 1'b0;
    repeat (6000) @(posedge clk);
    end_req = 1'b1;
    n = 0;
    while (n < 5000 && !(g_inst[0].done && g_inst[1].done)) begin
      @(posedge clk);
      n++;
    end
    if (!(g_inst[0].done && g_inst[1].done)) begin
      vectors++;
      miscompares++;
      $display("FAIL finish_timeout: end checks incomplete after %0d cycles", n);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
